// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the word-wide data-memory interface. Takes one
//   load/store request at a time, performs byte/halfword loads by lane
//   extraction with sign/zero extension, performs sub-word stores by
//   read-modify-write, and reports misaligned or illegal-size requests
//   without touching memory. Exactly one response pulse per request.
//
// Ports
//   clk, rst_n       clock (posedge) / asynchronous active-low reset
//   req_valid        request present
//   req_ready        unit idle, request accepted on valid & ready
//   req_write        1 = store, 0 = load
//   req_size         00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned     loads: 1 = zero-extend, 0 = sign-extend
//   req_addr         byte address
//   req_wdata        store data, right-justified
//   resp_valid       one-cycle response pulse
//   resp_rdata       extended load data (0 for stores and errors)
//   resp_err         misaligned / illegal size, qualified by resp_valid
//   mem_address      word-aligned byte address to memory
//   mem_write_data   full word written on the negedge of a STORE cycle
//   mem_read         memory read enable
//   mem_write        memory write enable
//   mem_read_data    combinational memory read data
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic              err_r;
  logic [DATA_W-1:0] word_r;      // store data, becomes the merged word after RMW_RD
  logic [DATA_W-1:0] rdata_r;

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_bad = 1'b0;
      SZ_HALF: is_bad = lo[0];
      SZ_WORD: is_bad = (lo != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  // Pick the addressed lane out of a memory word and extend it to DATA_W.
  // For aligned halfwords lo[0] is 0, so the same shift selects lane addr[1].
  function automatic logic [DATA_W-1:0] extend_lane(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        lo,
                                                    input logic [1:0]        size,
                                                    input logic              uns);
    logic [DATA_W-1:0]        shifted;
    logic signed [7:0]        lane_b;
    logic signed [15:0]       lane_h;
    logic signed [DATA_W-1:0] ext;
    shifted = word >> {lo, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    case (size)
      SZ_BYTE: begin
        if (uns) ext = $signed({{(DATA_W-8){1'b0}}, lane_b});
        else     ext = lane_b;
      end
      SZ_HALF: begin
        if (uns) ext = $signed({{(DATA_W-16){1'b0}}, lane_h});
        else     ext = lane_h;
      end
      default: ext = $signed(word);
    endcase
    extend_lane = ext;
  endfunction

  // Insert the low byte/halfword of the store data into the addressed lane,
  // keeping the remaining lanes of the word just read.
  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [1:0]        lo,
                                                   input logic [1:0]        size);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] ins;
    if (size == SZ_HALF) begin
      mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
    end else begin
      mask = {{(DATA_W-8){1'b0}}, 8'hFF};
    end
    ins        = (wdata & mask) << {lo, 3'b000};
    mask       = mask << {lo, 3'b000};
    merge_lane = (old & ~mask) | ins;
  endfunction

  // ---- request accept / memory access / response sequencing ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_r     <= '0;
      size_r     <= '0;
      unsigned_r <= 1'b0;
      err_r      <= 1'b0;
      word_r     <= '0;
      rdata_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_r     <= req_addr;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            word_r     <= req_wdata;
            err_r      <= is_bad(req_size, req_addr[1:0]);
            if (is_bad(req_size, req_addr[1:0])) begin
              // Response data changes only on entry to RESP.
              rdata_r <= '0;
              state   <= S_RESP;
            end else if (!req_write) begin
              state <= S_LOAD;
            end else if (req_size == SZ_WORD) begin
              state <= S_STORE;
            end else begin
              state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          rdata_r <= extend_lane(mem_read_data, addr_r[1:0], size_r, unsigned_r);
          state   <= S_RESP;
        end
        S_RMW_RD: begin
          word_r <= merge_lane(mem_read_data, word_r, addr_r[1:0], size_r);
          state  <= S_STORE;
        end
        S_STORE: begin
          rdata_r <= '0;
          state   <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- outputs decoded from registered state only ----
  assign req_ready      = (state == S_IDLE);
  assign resp_valid     = (state == S_RESP);
  assign resp_err       = (state == S_RESP) && err_r;
  assign resp_rdata     = rdata_r;
  assign mem_read       = (state == S_LOAD) || (state == S_RMW_RD);
  assign mem_write      = (state == S_STORE);
  assign mem_address    = {addr_r[ADDR_W-1:2], 2'b00};
  assign mem_write_data = word_r;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Bench for load_store_unit: a 16-word memory that commits on the negedge,
//   a byte-array reference model of memory contents, directed scenarios and
//   randomized request streams.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  int checks;
  int errors;

  logic [31:0] mem   [16] = '{default: '0};
  logic [31:0] model [16];

  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb mem_read_data = mem[mem_address[5:2]];

  always @(negedge clk) begin
    if (mem_write) mem[mem_address[5:2]] <= mem_write_data;
  end

  // ---- reference model ----
  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] sz,
                                         input logic u, input logic [31:0] a);
    logic [7:0]  b [4];
    logic [31:0] v;
    int k;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    k = a % 4;
    if (sz == 2'b00) begin
      v = {24'h0, b[k]};
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'h0, b[k+1], b[k]};
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [31:0] a);
    logic [7:0] b [4];
    int k;
    if (sz == 2'b10) return wd;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    k = a % 4;
    b[k] = wd[7:0];
    if (sz == 2'b01) b[k+1] = wd[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic int m_lat(input req_t r);
    if (m_err(r.sz, r.a)) return 1;
    if (!r.w || r.sz == 2'b10) return 2;
    return 3;
  endfunction

  // Drives one request (called #1 after a posedge) and observes it through
  // its response. lat counts edges from accept to the first resp_valid sample.
  task automatic issue(input req_t r, output int lat, output logic [31:0] rd,
                       output logic er, output int rdc, output int wrc,
                       output logic both, output logic again, output logic addr_bad,
                       output logic [31:0] wdata_seen);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_write = r.w; req_size = r.sz; req_unsigned = r.u;
    req_addr = r.a; req_wdata = r.wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; rdc = 0; wrc = 0; both = 1'b0; addr_bad = 1'b0; wdata_seen = '0;
    while (!resp_valid && lat < 10) begin
      if (mem_read)  rdc++;
      if (mem_write) begin wrc++; wdata_seen = mem_write_data; end
      if (mem_read && mem_write) both = 1'b1;
      if (mem_address != {r.a[31:2], 2'b00}) addr_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (resp_valid && (mem_read || mem_write)) both = 1'b1;
    @(posedge clk); #1;
    again = resp_valid;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {resp_valid, resp_err, mem_read, mem_write});
    end
    checks++;
    if (resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h want 0", resp_rdata, mem_address, mem_write_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    req_t tbl [13];
    int lat, rdc, wrc, idx;
    logic [31:0] rd, ws, exp_rd;
    logic er, both, again, abad, exp_e;
    tbl = '{
      '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF},
      '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0},
      '{1'b1, 2'b00, 1'b0, 32'h11, 32'h1234565A},
      '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0},
      '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0},
      '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0},
      '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0},
      '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0},
      '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0},
      '{1'b0, 2'b10, 1'b0, 32'h12, 32'h0},
      '{1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF},
      '{1'b1, 2'b11, 1'b0, 32'h10, 32'h5555},
      '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0}
    };
    for (int i = 0; i < 13; i++) begin
      idx   = tbl[i].a[5:2];
      exp_e = m_err(tbl[i].sz, tbl[i].a);
      exp_rd = (!tbl[i].w && !exp_e) ? m_load(model[idx], tbl[i].sz, tbl[i].u, tbl[i].a) : 32'h0;
      if (tbl[i].w && !exp_e) model[idx] = m_store(model[idx], tbl[i].wd, tbl[i].sz, tbl[i].a);
      issue(tbl[i], lat, rd, er, rdc, wrc, both, again, abad, ws);
      checks++;
      if (lat !== m_lat(tbl[i])) begin
        errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, m_lat(tbl[i]));
      end
      checks++;
      if (rd !== exp_rd || er !== exp_e) begin
        errors++; $display("FAIL dir%0d_resp got %h/%b want %h/%b", i, rd, er, exp_rd, exp_e);
      end
      checks++;
      if (rdc !== ((exp_e || (tbl[i].w && tbl[i].sz == 2'b10)) ? 0 : 1) ||
          wrc !== ((tbl[i].w && !exp_e) ? 1 : 0) || both || again) begin
        errors++; $display("FAIL dir%0d_memctl got rd=%0d wr=%0d both=%b again=%b", i, rdc, wrc, both, again);
      end
      checks++;
      if (mem[idx] !== model[idx] || (!exp_e && abad)) begin
        errors++; $display("FAIL dir%0d_memory got %h want %h addr_bad=%b", i, mem[idx], model[idx], abad);
      end
      if (tbl[i].w && !exp_e) begin
        checks++;
        if (ws !== model[idx]) begin
          errors++; $display("FAIL dir%0d_wdata got %h want %h", i, ws, model[idx]);
        end
      end
    end
  endtask

  task automatic test_random();
    req_t r;
    int lat, rdc, wrc, idx;
    logic [31:0] rd, ws, exp_rd;
    logic er, both, again, abad, exp_e;
    for (int i = 0; i < 60; i++) begin
      r.w  = 1'($urandom_range(0, 1));
      r.sz = 2'($urandom_range(0, 3));
      r.u  = 1'($urandom_range(0, 1));
      r.a  = 32'($urandom_range(0, 63));
      r.wd = $urandom;
      idx   = r.a[5:2];
      exp_e = m_err(r.sz, r.a);
      exp_rd = (!r.w && !exp_e) ? m_load(model[idx], r.sz, r.u, r.a) : 32'h0;
      if (r.w && !exp_e) model[idx] = m_store(model[idx], r.wd, r.sz, r.a);
      issue(r, lat, rd, er, rdc, wrc, both, again, abad, ws);
      checks++;
      if (lat !== m_lat(r) || rd !== exp_rd || er !== exp_e) begin
        errors++; $display("FAIL rnd%0d_resp got lat=%0d %h/%b want lat=%0d %h/%b (w=%b sz=%b a=%h)",
                           i, lat, rd, er, m_lat(r), exp_rd, exp_e, r.w, r.sz, r.a);
      end
      checks++;
      if (mem[idx] !== model[idx] || both || again || (!exp_e && abad) ||
          (exp_e && (rdc != 0 || wrc != 0))) begin
        errors++; $display("FAIL rnd%0d_memory got %h want %h both=%b again=%b rd=%0d wr=%0d",
                           i, mem[idx], model[idx], both, again, rdc, wrc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepted, acc_cyc [2], nresp, resp_cyc [2];
    logic [31:0] resp_d [2];
    logic pre_ready;
    logic [31:0] wd;
    wd = $urandom;
    accepted = 0; nresp = 0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = wd;
    for (int c = 0; c < 20; c++) begin
      pre_ready = req_ready;
      @(posedge clk); #1;
      if (pre_ready && req_valid) begin
        if (accepted < 2) acc_cyc[accepted] = c;
        accepted++;
        if (accepted == 1) begin
          req_write = 1'b0; req_wdata = 32'h0;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (resp_valid) begin
        if (nresp < 2) begin resp_d[nresp] = resp_rdata; resp_cyc[nresp] = c; end
        nresp++;
      end
    end
    req_valid = 1'b0;
    model[8] = wd;
    checks++;
    if (accepted !== 2 || nresp !== 2) begin
      errors++; $display("FAIL b2b_counts got acc=%0d resp=%0d want 2/2", accepted, nresp);
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 3 || resp_cyc[0] >= acc_cyc[1]) begin
        errors++; $display("FAIL b2b_order got acc %0d,%0d resp0 %0d want gap 3", acc_cyc[0], acc_cyc[1], resp_cyc[0]);
      end
      checks++;
      if (resp_d[0] !== 32'h0 || resp_d[1] !== wd) begin
        errors++; $display("FAIL b2b_data got %h,%h want 0,%h", resp_d[0], resp_d[1], wd);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_t r;
    int lat, rdc, wrc, n, stray;
    logic [31:0] rd, ws, prior;
    logic er, both, again, abad;
    prior = model[4];
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL rstmid_rmw got rd=%b wr=%b want 1/0", mem_read, mem_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0000 || mem_address !== 32'h0 ||
        mem_write_data !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_clear got ctl=%b addr=%h wd=%h rd=%h want all 0",
                         {resp_valid, resp_err, mem_read, mem_write}, mem_address, mem_write_data, resp_rdata);
    end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst_n = 1'b1;
      if (resp_valid || mem_write) stray++;
    end
    checks++;
    if (stray !== 0 || mem[4] !== prior) begin
      errors++; $display("FAIL rstmid_noresp got stray=%0d mem=%h want 0/%h", stray, mem[4], prior);
    end
    r = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0};
    issue(r, lat, rd, er, rdc, wrc, both, again, abad, ws);
    checks++;
    if (rd !== prior || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL rstmid_reload got %h/%b lat=%0d want %h/0 lat=2", rd, er, lat, prior);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
